// File: rtl/ring_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ring_in
// over back-to-back windows of GATE_CYCLES clocks and publishes a saturated count.
module ring_freq_counter #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_COUNT   = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ring_in,
    input  logic             enable,
    output logic [CNT_W-1:0] bin,
    output logic             valid,
    output logic             ovf
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync_d_r;
    logic             edge_p_s;
    logic [GW-1:0]    gate_cnt_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic             ovf_acc_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ovf_next_s;

    // Two-flop synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            sync_d_r <= 1'b0;
        end else begin
            sync1_r  <= ring_in;
            sync2_r  <= sync1_r;
            sync_d_r <= sync2_r;
        end
    end

    assign edge_p_s = sync2_r & ~sync_d_r;

    // Saturating edge accumulation; an edge lost at the ceiling flags overflow.
    always_comb begin
        cnt_next_s = edge_cnt_r;
        ovf_next_s = ovf_acc_r;
        if (edge_p_s) begin
            if (edge_cnt_r == MAX_C) begin
                ovf_next_s = 1'b1;
            end else begin
                cnt_next_s = edge_cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = edge_cnt_r;
        end
    end

    // Gate-window FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gate_cnt_r <= {GW{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            ovf_acc_r  <= 1'b0;
            bin        <= {CNT_W{1'b0}};
            ovf        <= 1'b0;
            valid      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    gate_cnt_r <= {GW{1'b0}};
                    edge_cnt_r <= {CNT_W{1'b0}};
                    ovf_acc_r  <= 1'b0;
                    valid      <= 1'b0;
                    if (enable) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        // Partial window is dropped; bin and ovf keep the last result.
                        state_r    <= IDLE;
                        gate_cnt_r <= {GW{1'b0}};
                        edge_cnt_r <= {CNT_W{1'b0}};
                        ovf_acc_r  <= 1'b0;
                        valid      <= 1'b0;
                    end else if (gate_cnt_r == GATE_LAST) begin
                        bin        <= cnt_next_s;
                        ovf        <= ovf_next_s;
                        valid      <= 1'b1;
                        gate_cnt_r <= {GW{1'b0}};
                        edge_cnt_r <= {CNT_W{1'b0}};
                        ovf_acc_r  <= 1'b0;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + GATE_ONE;
                        edge_cnt_r <= cnt_next_s;
                        ovf_acc_r  <= ovf_next_s;
                        valid      <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    gate_cnt_r <= {GW{1'b0}};
                    edge_cnt_r <= {CNT_W{1'b0}};
                    ovf_acc_r  <= 1'b0;
                    valid      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_freq_counter.sv
// Scoreboard bench for ring_freq_counter: ring_in is generated with whole-clock
// periods dividing the 100-cycle gate, so every window holds an exact edge count.
module tb_ring_freq_counter;

    localparam int G    = 100;
    localparam int MAXC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ring_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bin;
    logic        valid;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_bin_q[$];
    logic        exp_ovf_q[$];

    int   high_len = 0;
    int   low_len = 0;
    logic const_level = 1'b0;
    int   phase_cnt = 0;

    ring_freq_counter #(
        .GATE_CYCLES(G),
        .CNT_W(16),
        .MAX_COUNT(MAXC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ring_in(ring_in),
        .enable(enable),
        .bin(bin),
        .valid(valid),
        .ovf(ovf)
    );

    always #10 clk = ~clk;

    // ring_in generator: high_len cycles high, low_len cycles low; 0 means constant.
    always @(negedge clk) begin
        if (high_len == 0) begin
            ring_in = const_level;
            phase_cnt = 0;
        end else begin
            phase_cnt++;
            if (ring_in && phase_cnt >= high_len) begin
                ring_in = 1'b0;
                phase_cnt = 0;
            end else if (!ring_in && phase_cnt >= low_len) begin
                ring_in = 1'b1;
                phase_cnt = 0;
            end
        end
    end

    // Monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin : monitor
        logic [15:0] eb;
        logic        eo;
        if (rst_n && valid) begin
            vectors++;
            if (exp_bin_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: bin=%0d ovf=%0d, required no pulse", bin, ovf);
            end else begin
                eb = exp_bin_q.pop_front();
                eo = exp_ovf_q.pop_front();
                if (bin !== eb || ovf !== eo) begin
                    miscompares++;
                    $display("FAIL window: bin=%0d ovf=%0d, required bin=%0d ovf=%0d", bin, ovf, eb, eo);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_bin_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_bin_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d windows outstanding, required 0", exp_bin_q.size());
            exp_bin_q.delete();
            exp_ovf_q.delete();
        end
    endtask

    task automatic run_phase(input int hl, input int ll, input logic cl, input int nwin,
                             input logic [15:0] eb, input logic eo);
        enable = 1'b0;
        high_len = hl;
        low_len = ll;
        const_level = cl;
        repeat (30) @(negedge clk);
        for (int i = 0; i < nwin; i++) begin
            exp_bin_q.push_back(eb);
            exp_ovf_q.push_back(eo);
        end
        enable = 1'b1;
        drain(nwin * G + 50);
        enable = 1'b0;
    endtask

    initial begin
        int n;
        #15;
        check("reset_bin", bin, 16'd0);
        check("reset_valid", {15'd0, valid}, 16'd0);
        check("reset_ovf", {15'd0, ovf}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_phase(5, 5, 1'b0, 3, 16'd10, 1'b0);   // period 10 -> 10 edges
        run_phase(2, 2, 1'b0, 3, 16'd20, 1'b1);   // 25 edges, saturates at 20
        run_phase(2, 3, 1'b0, 2, 16'd20, 1'b0);   // exactly MAX_COUNT, no overflow
        run_phase(10, 10, 1'b0, 2, 16'd5, 1'b0);

        // Mid-window disable: no pulse, result holds, then restart latency.
        run_phase(5, 5, 1'b0, 1, 16'd10, 1'b0);
        enable = 1'b1;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (150) @(negedge clk);
        check("hold_bin", bin, 16'd10);
        check("hold_ovf", {15'd0, ovf}, 16'd0);
        exp_bin_q.push_back(16'd10);
        exp_ovf_q.push_back(1'b0);
        enable = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (valid) break;
        end
        check("reenable_latency", 16'(n), 16'(G + 1));
        enable = 1'b0;
        drain(5);

        run_phase(0, 0, 1'b1, 2, 16'd0, 1'b0);    // constant high
        run_phase(0, 0, 1'b0, 2, 16'd0, 1'b0);    // constant low

        // Asynchronous reset in the middle of a window.
        run_phase(5, 5, 1'b0, 1, 16'd10, 1'b0);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_bin", bin, 16'd0);
        check("midreset_valid", {15'd0, valid}, 16'd0);
        check("midreset_ovf", {15'd0, ovf}, 16'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_phase(5, 5, 1'b0, 2, 16'd10, 1'b0);

        repeat (150) @(negedge clk);
        check("queue_empty", 16'(exp_bin_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
